// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares one alarm serial channel (send strobe + data line) between N_REQ
// requesters. Grants round-robin, sends a one-cycle header strobe, shifts the
// latched message out LSB first, then holds a stand-by gap of SB+1 cycles.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   EN         arbitration enable, gates only the start of new frames
//   SB         stand-by count, gap lasts SB+1 cycles (sampled on gap entry)
//   req        level request per requester, held until its ack
//   msg        packed messages, requester i at [i*MSG_W +: MSG_W]
//   ack        one-cycle pulse to the owner in the first gap cycle
//   grant      one-hot owner of the current frame, 0 when idle
//   busy       high in HDR, DATA and GAP
//   state_send frame start strobe
//   state_out  serial data line
module serial_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int MSG_W = 4,
    parameter int SB_W  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [SB_W-1:0]          SB,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*MSG_W-1:0]   msg,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     state_send,
    output logic                     state_out
);

    localparam int RR_W = $clog2(N_REQ);
    localparam int RS_W = RR_W + 1;
    localparam int BC_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam int GC_W = SB_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [RR_W-1:0]    own_q, own_d;
    logic [MSG_W-1:0]   sh_q, sh_d;
    logic [BC_W-1:0]    bit_q, bit_d;
    logic [GC_W-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               send_q, send_d;
    logic               out_q, out_d;

    logic               win_found_s;
    logic [RR_W-1:0]    win_idx_s;
    logic [RS_W-1:0]    cand_s;
    logic [MSG_W-1:0]   win_msg_s;

    // Round-robin scan: first set request starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, rr_q} + RS_W'(i);
            if (cand_s >= RS_W'(N_REQ)) begin
                cand_s = cand_s - RS_W'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req[cand_s[RR_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[RR_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Message of the scan winner, captured into the shift register at grant.
    always_comb begin
        win_msg_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_idx_s == RR_W'(j)) begin
                win_msg_s = msg[j*MSG_W +: MSG_W];
            end else begin
                win_msg_s = win_msg_s;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        ack_d   = '0;
        grant_d = grant_q;
        busy_d  = 1'b1;
        send_d  = 1'b0;
        out_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                grant_d = '0;
                if (EN && win_found_s) begin
                    state_d            = HDR;
                    own_d              = win_idx_s;
                    sh_d               = win_msg_s;
                    grant_d[win_idx_s] = 1'b1;
                    send_d             = 1'b1;
                    busy_d             = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                state_d = DATA;
                out_d   = sh_q[0];
                sh_d    = sh_q >> 1;
                bit_d   = '0;
            end
            DATA: begin
                if (bit_q == BC_W'(MSG_W - 1)) begin
                    state_d       = GAP;
                    ack_d[own_q]  = 1'b1;
                    grant_d       = '0;
                    // Gap counter is one bit wider than SB so SB all-ones still fits SB+1.
                    gap_d         = {1'b0, SB} + GC_W'(1);
                    if (own_q == RR_W'(N_REQ - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = own_q + RR_W'(1);
                    end
                end else begin
                    out_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + BC_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GC_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - GC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= '0;
            own_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            send_q  <= send_d;
            out_q   <= out_d;
        end
    end

    assign ack        = ack_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign state_send = send_q;
    assign state_out  = out_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: frame-level reference model feeds an
// expected-frame queue; an independent monitor decodes the serial link and
// compares each decoded frame against the queue.
module tb_serial_tx_arbiter;

    localparam int N     = 4;
    localparam int MSG_W = 4;
    localparam int SB_W  = 4;

    logic               CLK;
    logic               RST;
    logic               EN;
    logic [SB_W-1:0]    SB;
    logic [N-1:0]       req;
    logic [N*MSG_W-1:0] msg;
    logic [N-1:0]       ack;
    logic [N-1:0]       grant;
    logic               busy;
    logic               state_send;
    logic               state_out;

    serial_tx_arbiter #(.N_REQ(N), .MSG_W(MSG_W), .SB_W(SB_W)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SB(SB), .req(req), .msg(msg),
        .ack(ack), .grant(grant), .busy(busy),
        .state_send(state_send), .state_out(state_out)
    );

    typedef struct {
        logic [N-1:0]     grant;
        logic [MSG_W-1:0] msg;
        int               sb;
        bit               b2b;
    } exp_t;

    exp_t             expq[$];
    logic [MSG_W-1:0] msgs_m [N];
    int               rr_m;
    int               n_chk;
    int               n_fail;
    int               frames_done;
    bit               mon_en;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic pack_msgs();
        for (int i = 0; i < N; i++) msg[i*MSG_W +: MSG_W] = msgs_m[i];
    endtask

    // Reference: pending set s is served in cyclic order starting at rr_m.
    task automatic model_push(input logic [N-1:0] s, input int k, input int sbv);
        int p;
        exp_t e;
        p = rr_m;
        for (int n = 0; n < k; n++) begin
            while (!s[p]) p = (p + 1) % N;
            e.grant = '0;
            e.grant[p] = 1'b1;
            e.msg = msgs_m[p];
            e.sb = sbv;
            e.b2b = (n > 0);
            expq.push_back(e);
            p = (p + 1) % N;
        end
        rr_m = p;
    endtask

    task automatic wait_frames(input int target);
        int cyc;
        cyc = 0;
        while (frames_done < target && cyc < 400) begin
            @(negedge CLK);
            cyc++;
        end
        chk("frames_done", frames_done, target);
    endtask

    // pers: requesters keep req high after ack, all drop after the k-th ack.
    task automatic run_phase(input logic [N-1:0] s, input int k, input bit pers, input int sbv);
        int acks;
        int target;
        int cyc;
        acks = 0;
        cyc = 0;
        pack_msgs();
        SB = sbv[SB_W-1:0];
        req = s;
        model_push(s, k, sbv);
        target = frames_done + k;
        @(negedge CLK);
        EN = 1'b1;
        while (acks < k && cyc < 60 * k + 40) begin
            @(negedge CLK);
            cyc++;
            if (ack != '0) begin
                acks++;
                if (pers) begin
                    if (acks == k) req = '0;
                end else begin
                    req = req & ~ack;
                end
            end
        end
        chk("ack_count", acks, k);
        wait_frames(target);
        EN = 1'b0;
        req = '0;
    endtask

    // Monitor: decodes header / data / gap from the link and checks against the queue.
    initial begin
        int mph;
        int k;
        int gapn;
        int idle_cnt;
        logic [MSG_W-1:0] bits;
        logic [N-1:0] ea;
        exp_t cur;
        mph = 0; k = 0; gapn = 0; idle_cnt = 0; bits = '0;
        cur.grant = '0; cur.msg = '0; cur.sb = 0; cur.b2b = 1'b0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                mph = 0;
                idle_cnt = 0;
            end else if (mph == 0) begin
                if (state_send) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                        cur.grant = '0; cur.msg = '0; cur.sb = 0; cur.b2b = 1'b0;
                    end else begin
                        cur = expq.pop_front();
                    end
                    chk("grant_at_hdr", grant, cur.grant);
                    chk("busy_at_hdr", busy, 1);
                    chk("out_at_hdr", state_out, 0);
                    if (cur.b2b) chk("idle_between_frames", idle_cnt, 1);
                    k = 0;
                    mph = 1;
                end else begin
                    chk("idle_quiet", {ack, grant, busy, state_out}, 0);
                    idle_cnt++;
                end
            end else if (mph == 1) begin
                bits[k] = state_out;
                chk("data_ctl", {state_send, ack, grant, busy}, {1'b0, {N{1'b0}}, cur.grant, 1'b1});
                k++;
                if (k == MSG_W) begin
                    chk("data_bits", bits, cur.msg);
                    gapn = 0;
                    mph = 2;
                end
            end else begin
                if (busy) begin
                    gapn++;
                    ea = (gapn == 1) ? cur.grant : {N{1'b0}};
                    chk("gap_ack", ack, ea);
                    chk("gap_quiet", {state_send, state_out, grant}, 0);
                    if (gapn > 40) begin
                        chk("gap_timeout", gapn, cur.sb + 1);
                        mph = 0;
                    end
                end else begin
                    chk("gap_len", gapn, cur.sb + 1);
                    chk("idle_quiet", {ack, grant, state_send, state_out}, 0);
                    frames_done++;
                    idle_cnt = 1;
                    mph = 0;
                end
            end
        end
    end

    initial begin
        logic [N-1:0] s;
        int kk;
        int sbv;
        int tgt;
        int cyc;
        bit pers;
        n_chk = 0; n_fail = 0; frames_done = 0; rr_m = 0; mon_en = 1'b0;
        RST = 1'b1; EN = 1'b0; SB = '0; req = '0; msg = '0;
        for (int i = 0; i < N; i++) msgs_m[i] = '0;
        #1;
        chk("reset_outputs", {ack, grant, busy, state_send, state_out}, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;

        // Single request after reset: bits 0,1,0,1 and a 3-cycle gap.
        msgs_m[0] = 4'hA;
        run_phase(4'b0001, 1, 1'b1, 2);

        // Contention, all requesters held, 7-cycle frames.
        msgs_m[0] = 4'h1; msgs_m[1] = 4'h2; msgs_m[2] = 4'h3; msgs_m[3] = 4'h4;
        run_phase(4'b1111, 5, 1'b1, 0);

        // Pointer wrap after serving requester 3.
        run_phase(4'b1000, 1, 1'b1, 1);
        run_phase(4'b1001, 1, 1'b1, 1);
        run_phase(4'b0011, 1, 1'b1, 1);

        // EN gating: pending request waits, then EN drops mid-frame.
        msgs_m[1] = 4'h6;
        pack_msgs();
        SB = 4'd1;
        req = 4'b0010;
        repeat (10) begin
            @(negedge CLK);
            chk("en_gate_grant", grant, 0);
            chk("en_gate_busy", busy, 0);
        end
        model_push(4'b0010, 1, 1);
        tgt = frames_done + 1;
        EN = 1'b1;
        repeat (3) @(negedge CLK);
        EN = 1'b0;
        wait_frames(tgt);
        repeat (12) begin
            @(negedge CLK);
            chk("en_off_no_grant", grant, 0);
        end
        req = '0;

        // Mid-frame msg change and req drop, SB change during gap.
        msgs_m[1] = 4'h9;
        pack_msgs();
        SB = 4'd2;
        req = 4'b0010;
        model_push(4'b0010, 1, 2);
        tgt = frames_done + 1;
        @(negedge CLK);
        EN = 1'b1;
        repeat (3) @(negedge CLK);
        msg[1*MSG_W +: MSG_W] = 4'h6;
        req = '0;
        cyc = 0;
        while (ack == '0 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("midframe_ack", ack, 4'b0010);
        SB = 4'd9;
        wait_frames(tgt);
        EN = 1'b0;

        // Async reset in the middle of DATA.
        msgs_m[2] = 4'h5;
        pack_msgs();
        SB = 4'd1;
        req = 4'b0100;
        model_push(4'b0100, 1, 1);
        @(negedge CLK);
        EN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_outputs", {ack, grant, busy, state_send, state_out}, 0);
        req = '0;
        EN = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("rst_hold", {ack, grant, busy, state_send, state_out}, 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        expq.delete();
        rr_m = 0;
        mon_en = 1'b1;
        msgs_m[1] = 4'hC; msgs_m[2] = 4'h3;
        run_phase(4'b0110, 1, 1'b1, 1);

        // Randomized phases.
        for (int ph = 0; ph < 10; ph++) begin
            s = N'($urandom_range(1, (1 << N) - 1));
            pers = 1'($urandom_range(0, 1));
            sbv = (ph == 3) ? 15 : int'($urandom_range(0, 5));
            for (int i = 0; i < N; i++) msgs_m[i] = MSG_W'($urandom);
            kk = pers ? int'($urandom_range(1, 6)) : $countones(s);
            run_phase(s, kk, pers, sbv);
        end

        repeat (4) @(negedge CLK);
        chk("queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
